// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with row sync/debounce, valid/ready key output and 2-digit history.
// Optional KEYPAD_GHOST_REJECT_EN: reject multi-row hits at sample time and during debounce.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic [7:0] digits,
    output logic       key_held,
    output logic       key_ovf
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
    // nibble {row, col}: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = E 0 F D
    localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
`ifdef KEYPAD_GHOST_REJECT_EN
    localparam logic GHOST = 1'b1;
`else
    localparam logic GHOST = 1'b0;
`endif

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE_DB} state_t;

    state_t          state_q, state_d;
    logic [3:0]      row_m, row_s, col_q, col_d, col_next, code;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      r_q, r_d, c_idx, low_row;
    logic            hit, multi, sample_ok, abort_db, accept;

    assign col_next  = {col_q[2:0], col_q[3]};
    assign c_idx     = col_q[3] ? 2'd3 : col_q[2] ? 2'd2 : col_q[1] ? 2'd1 : 2'd0;
    assign low_row   = row_s[0] ? 2'd0 : row_s[1] ? 2'd1 : row_s[2] ? 2'd2 : 2'd3;
    assign multi     = |(row_s & (row_s - 4'd1));
    assign hit       = row_s[r_q];
    assign sample_ok = |row_s && !(GHOST && multi);
    assign abort_db  = !hit || (GHOST && multi);
    assign code      = KEYMAP[{r_q, c_idx, 2'b00} +: 4];
    assign col_o     = col_q;
    assign key_held  = (state_q == HELD) || (state_q == RELEASE_DB);

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        col_d   = col_q;
        accept  = 1'b0;
        case (state_q)
            SCAN: begin
                dwell_d = (dwell_q == DW'(SCAN_DIV - 1)) ? '0 : dwell_q + 1'b1;
                if (dwell_q == DW'(SCAN_DIV - 1)) begin
                    if (sample_ok) begin
                        state_d = DEBOUNCE;
                        r_d     = low_row;
                        cnt_d   = '0;
                    end else begin
                        col_d = col_next;
                    end
                end
            end
            DEBOUNCE: begin
                if (abort_db) begin
                    state_d = SCAN;
                    col_d   = col_next;
                end else if (cnt_q == CW'(DEBOUNCE_CNT - 1)) begin
                    state_d = HELD;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                state_d = hit ? HELD : RELEASE_DB;
                cnt_d   = '0;
            end
            RELEASE_DB: begin
                if (hit) begin
                    state_d = HELD;
                end else if (cnt_q == CW'(DEBOUNCE_CNT - 1)) begin
                    state_d = SCAN;
                    col_d   = col_next;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_m     <= '0;
            row_s     <= '0;
            state_q   <= SCAN;
            dwell_q   <= '0;
            cnt_q     <= '0;
            r_q       <= '0;
            col_q     <= 4'b0001;
            key_valid <= 1'b0;
            key_code  <= '0;
            digits    <= '0;
            key_ovf   <= 1'b0;
        end else begin
            row_m   <= row_i;
            row_s   <= row_m;
            state_q <= state_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            col_q   <= col_d;
            if (accept) begin
                digits <= {digits[3:0], code};
                if (!key_valid || key_ready) begin
                    key_code  <= code;
                    key_valid <= 1'b1;
                end else begin
                    key_ovf <= 1'b1;
                end
            end else if (key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: physical keypad model drives rows from col_o; scoreboard queue checks every handshaked key.
module tb_keypad_scan_ctrl;
    localparam int SD = 4;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_ready = 1'b0;
    logic [3:0] row_i, col_o, key_code;
    logic       key_valid, key_held, key_ovf;
    logic [7:0] digits;
    logic [15:0] pk = '0;

    int   vectors = 0;
    int   errors = 0;
    int   q[$];
    logic [7:0] hist = '0;
    bit   rand_rdy = 1'b0;
    int   keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk(clk), .rst(rst), .row_i(row_i), .col_o(col_o),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .digits(digits), .key_held(key_held), .key_ovf(key_ovf)
    );

    always #5 clk = ~clk;

    // pressed key (r,c) shorts row r to column c
    always_comb begin
        row_i = '0;
        for (int r = 0; r < 4; r++) row_i[r] = |(pk[r*4 +: 4] & col_o);
    end

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && key_valid && key_ready) begin
            vectors++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_key: got %0h expected none at %0t", key_code, $time);
            end else begin
                int e;
                e = q.pop_front();
                if (int'(key_code) != e) begin
                    errors++;
                    $display("FAIL key_code: got %0h expected %0h at %0t", key_code, e, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) key_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic expect_key(int k, bit deliver);
        if (deliver) q.push_back(keymap[k/4][k%4]);
        hist = {hist[3:0], 4'(keymap[k/4][k%4])};
    endtask

    task automatic press(int k, int hold, int lo, int hi);
        pk = '0;
        pk[k] = 1'b1;
        repeat (hold) tick();
        if (lo > 0) begin
            pk = '0;
            repeat (lo) tick();
            pk[k] = 1'b1;
            repeat (hi) tick();
        end
        pk = '0;
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_col"}, col_o, 1);
        chk({tag, "_valid"}, key_valid, 0);
        chk({tag, "_code"}, key_code, 0);
        chk({tag, "_digits"}, digits, 0);
        chk({tag, "_held"}, key_held, 0);
        chk({tag, "_ovf"}, key_ovf, 0);
    endtask

    // returns in the first cycle of a column-0 dwell window
    task automatic wait_col0();
        int n;
        logic [3:0] p;
        n = 0;
        do begin
            p = col_o;
            tick();
            n++;
        end while (!(col_o == 4'b0001 && p != 4'b0001) && n < 64);
        chk("col0_wait", int'(col_o == 4'b0001 && p != 4'b0001), 1);
    endtask

    initial begin
        int n, k;
        repeat (3) tick();
        chk_reset("reset");
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            chk("col_rot", col_o, 1 << ((j / SD) % 4));
            tick();
        end
        chk("idle_valid", key_valid, 0);
        chk("idle_digits", digits, 0);

        // two rows on column 0, then reset in the middle of debounce
        key_ready = 1'b1;
        wait_col0();
        pk = 16'h0011;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        chk_reset("mid_rst");
        rst = 1'b0;
        hist = '0;
`ifndef KEYPAD_GHOST_REJECT_EN
        expect_key(0, 1'b1);
`endif
        repeat (60) tick();
        pk = '0;
        repeat (30) tick();
        chk("ghost_digits", digits, hist);

        // key 6 held with consumer stalled
        key_ready = 1'b0;
        expect_key(6, 1'b1);
        pk = '0;
        pk[6] = 1'b1;
        n = 0;
        while (!key_valid && n < 80) begin
            tick();
            n++;
        end
        chk("k6_valid", key_valid, 1);
        chk("k6_code", key_code, 6);
        chk("k6_digits", digits, hist);
        chk("k6_held", key_held, 1);
        repeat (5) tick();
        chk("k6_valid_hold", key_valid, 1);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        chk("k6_consumed", key_valid, 0);
        pk = '0;
        repeat (30) tick();
        chk("k6_released", key_held, 0);

        // short pulse during debounce: abort and resume on the next column
        key_ready = 1'b1;
        wait_col0();
        pk = 16'h0001;
        repeat (7) tick();
        pk = '0;
        repeat (2) tick();
        chk("pulse_frozen", col_o, 4'b0001);
        tick();
        chk("pulse_next_col", col_o, 4'b0010);
        repeat (4) tick();
        chk("pulse_col2", col_o, 4'b0100);
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 15)) tick();
            press($urandom_range(0, 15), 3, 0, 0);
            repeat (12) tick();
        end
        chk("pulse_digits", digits, hist);

        // release bounce yields a single key
        expect_key(2, 1'b1);
        press(2, 45, 3, 2);
        repeat (30) tick();
        chk("bounce_digits", digits, hist);

        // second key dropped while first is pending
        key_ready = 1'b0;
        expect_key(5, 1'b1);
        press(5, 50, 0, 0);
        repeat (30) tick();
        expect_key(10, 1'b0);
        press(10, 50, 0, 0);
        repeat (30) tick();
        chk("ovf_valid", key_valid, 1);
        chk("ovf_code", key_code, 5);
        chk("ovf_flag", key_ovf, 1);
        chk("ovf_digits", digits, hist);
        key_ready = 1'b1;
        tick();
        chk("ovf_consumed", key_valid, 0);
        chk("ovf_sticky", key_ovf, 1);

        // randomized presses with random consumer readiness
        rand_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            k = $urandom_range(0, 15);
            expect_key(k, 1'b1);
            press(k, $urandom_range(45, 70), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0,
                  $urandom_range(2, 4));
            repeat ($urandom_range(30, 50)) tick();
            chk("rand_digits", digits, hist);
        end
        rand_rdy = 1'b0;
        key_ready = 1'b1;
        repeat (10) tick();
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Sequencing controller for the 4x4 matrix keypad. It drives one-hot column strobes at a programmable dwell rate and synchronizes and debounces the row returns. Each debounced press is turned into exactly one hex key code, offered on a valid/ready output. It sits between the keypad pins and the display/digit logic, and also keeps a two-digit key history for the seven-segment mux.

## Interface
Parameters:
- SCAN_DIV, 4: clock cycles each column is driven; must be ≥3.
- DEBOUNCE_CNT, 8: consecutive stable cycles required to accept a press or a release; must be ≥2.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- row_i  in  4  raw keypad rows, active-high, asynchronous to clk.
- col_o  out  4  one-hot active-high column drive.
- key_valid  out  1  key_code holds an unconsumed key.
- key_code  out  4  hex value of the accepted key.
- key_ready  in  1  consumer accepts when key_valid && key_ready.
- digits  out  8  {older, newest} key history for display.
- key_held  out  1  high while in HELD or RELEASE_DB.
- key_ovf  out  1  sticky: a key was dropped because key_valid was still pending.

## Operation
- row_i passes through a 2-flop synchronizer; row_s is the output. All decisions use row_s.
- States: SCAN, DEBOUNCE, HELD, RELEASE_DB.
- **SCAN:**
  - Dwell counter runs 0..SCAN_DIV-1. col_o rotates 0001→0010→0100→1000→0001 when the counter wraps.
  - row_s is sampled only on the last dwell cycle. If it is nonzero, latch r = lowest set row index and c = active column, then go to DEBOUNCE. col_o stays frozen.
- **DEBOUNCE:**
  - Counter starts at 0 and increments each cycle while row_s[r]=1.
  - If row_s[r]=0, return to SCAN and advance to the next column.
  - When the counter reaches DEBOUNCE_CNT-1 with row_s[r]=1, accept the key and go to HELD.
- **HELD:** col_o stays frozen. When row_s[r]=0, go to RELEASE_DB with the counter at 0.
- **RELEASE_DB:**
  - Counts cycles with row_s[r]=0. If row_s[r]=1, go back to HELD; no new key is produced.
  - At DEBOUNCE_CNT-1, go to SCAN and advance to the next column.
- Other rows and columns are ignored outside SCAN. One press yields exactly one key.
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- **On accept:**
  - digits ← {digits[3:0], code}. This happens regardless of the handshake.
  - If key_valid=0, or key_ready=1 in the same cycle, key_code ← code and key_valid ← 1.
  - Otherwise the new key is dropped, key_code is unchanged, and key_ovf ← 1.
- key_valid clears on the cycle after key_valid && key_ready, unless a new key loads in that same cycle.

## Timing
- Reset values: col_o=0001, key_valid=0, key_code=0, digits=00, key_held=0, key_ovf=0, state SCAN, all counters 0, synchronizer flops 0.
- A rst assertion mid-press aborts at once. The next cycle shows the reset values, and a still-held key is re-debounced from SCAN.
- Latency: a row_i change is visible in row_s 2 cycles later.
- Key acceptance:
  - The SCAN sample cycle is followed by DEBOUNCE_CNT cycles in DEBOUNCE.
  - key_valid, key_code and digits update on the clock edge ending the last DEBOUNCE cycle.
  - This is DEBOUNCE_CNT+1 edges after the sample edge.
- key_held rises the same edge key_valid does. It falls the edge RELEASE_DB exits.
- key_ready is combinationally unused; acceptance takes effect on the next edge.

## Configuration
- KEYPAD_GHOST_REJECT_EN defined: more than one row_s bit set at the SCAN sample is not latched, and scanning continues. More than one row_s bit set during DEBOUNCE aborts to SCAN.
- KEYPAD_GHOST_REJECT_EN undefined: the lowest set row index wins, and other rows are ignored.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_CNT=8.
- Reset for 3 cycles, then idle 20 cycles → col_o cycles 0001,0010,0100,1000 every 4 cycles; key_valid=0; digits=00.
- row_i=0010 held while col_o=0100, key_ready=0 → key_code=6, key_valid=1 held, digits=0x06, key_held=1. Then key_ready=1 for one cycle → key_valid=0 next edge.
- row_i=0001 pulse of 3 cycles during DEBOUNCE → no key; scan resumes at the next column; digits unchanged.
- After an accepted release, row_i bounces low 3 cycles, high 2 cycles, then low → exactly one key, no second acceptance.
- Press 5 (r1,c1) and then 9 (r2,c2) with key_ready=0 → key_code=5, key_ovf=1, digits=0x59.
- row_i=0011 during col 0001:
  - With the macro defined → no key.
  - With the macro undefined → key_code=1.
  - Assert rst mid-DEBOUNCE → all outputs return to their reset values next edge.
